led_blink_code: RTL and testbench

//  Status-LED sequencer sitting directly downstream of the LED fader. In idle it passes the

---
 rtl/led_blink_code_pkg.sv | 34 +++
 rtl/led_blink_code_tick_prescaler.sv | 36 +++
 rtl/led_blink_code.sv | 170 +++++++++++++++++
 tb/tb_led_blink_code.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/led_blink_code_pkg.sv
// ---------------------------------------------------------------------------
// led_blink_code_pkg
// Shared definitions for the status-LED path: FSM state encodings for the
// blink-code sequencer and the default blink timing, also used by the fader
// wrapper so both sides agree on the same pattern.
// No ports (package).
// ---------------------------------------------------------------------------
package led_blink_code_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Default timing, in prescaler ticks / full sequence repeats
  localparam int DEF_ON_TICKS  = 2;
  localparam int DEF_OFF_TICKS = 3;
  localparam int DEF_GAP_TICKS = 10;
  localparam int DEF_REPEATS   = 3;

  // Bits needed to hold the values 0..maxVal (maxVal >= 1)
  function automatic int widthFor(input int maxVal);
    return $clog2(maxVal + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/led_blink_code_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Free-running MXTICKCNT-bit counter producing a one-clock tick each time the
// counter is all-ones (one tick every 2**MXTICKCNT clocks). A synchronous
// clear restarts the count so the first tick after it lands a full period later.
// Ports:
//   i_clock  in   system clock
//   i_reset  in   asynchronous, active-high reset
//   i_clear  in   synchronous clear of the counter
//   o_tick   out  1-cycle tick pulse
// ---------------------------------------------------------------------------
module tick_prescaler #(
  parameter int MXTICKCNT = 22
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  logic [MXTICKCNT-1:0] r_count;

  // Counter wraps naturally; clear wins over counting
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick = &r_count;

endmodule

// File: rtl/led_blink_code.sv
// ---------------------------------------------------------------------------
// led_blink_code
// Status-LED sequencer downstream of the LED fader. Idle: passes the fader
// waveform to the LED. On an accepted nonzero status code N: N blinks then a
// dark gap, repeated REPEATS times, then back to the fader waveform.
// Ports:
//   i_clock       in   system clock
//   i_reset       in   asynchronous, active-high reset
//   i_fade_in     in   PWM breathing waveform (same clock domain)
//   i_code        in   status code to display
//   i_code_valid  in   code is presented
//   o_code_ready  out  high only while idle (combinational)
//   o_led         out  registered LED drive
//   o_busy        out  registered, high while a code is being shown
// ---------------------------------------------------------------------------
module led_blink_code
  import led_blink_code_pkg::*;
#(
  parameter int MXTICKCNT  = 22,
  parameter int MXCODEBITS = 4,
  parameter int ON_TICKS   = DEF_ON_TICKS,
  parameter int OFF_TICKS  = DEF_OFF_TICKS,
  parameter int GAP_TICKS  = DEF_GAP_TICKS,
  parameter int REPEATS    = DEF_REPEATS
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_fade_in,
  input  logic [MXCODEBITS-1:0] i_code,
  input  logic                  i_code_valid,
  output logic                  o_code_ready,
  output logic                  o_led,
  output logic                  o_busy
);

  localparam int PH_W  = widthFor(max3(ON_TICKS, OFF_TICKS, GAP_TICKS));
  localparam int REP_W = widthFor(REPEATS);

  // Phase counter holds 0..X-1; the transition happens on the X-th tick
  localparam logic [PH_W-1:0]  ON_LAST  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]  OFF_LAST = PH_W'(OFF_TICKS - 1);
  localparam logic [PH_W-1:0]  GAP_LAST = PH_W'(GAP_TICKS - 1);
  localparam logic [REP_W-1:0] REP_INIT = REP_W'(REPEATS);

  state_t                r_state;
  logic [PH_W-1:0]       r_phase;
  logic [MXCODEBITS-1:0] r_blinkCnt;
  logic [MXCODEBITS-1:0] r_code;
  logic [REP_W-1:0]      r_repCnt;
  logic                  r_led;
  logic                  r_busy;

  state_t                w_nextState;
  logic [PH_W-1:0]       w_nextPhase;
  logic [MXCODEBITS-1:0] w_nextBlink;
  logic [REP_W-1:0]      w_nextRep;
  logic                  w_nextLed;
  logic                  w_nextBusy;
  logic                  w_start;
  logic                  w_tick;

  assign o_code_ready = (r_state == ST_IDLE);

  // A zero code completes the handshake but never starts a sequence
  assign w_start = i_code_valid && o_code_ready && (i_code != '0);

  // Clearing on start makes the first ON phase exactly ON_TICKS ticks long
  tick_prescaler #(
    .MXTICKCNT (MXTICKCNT)
  ) u_prescaler (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (w_start),
    .o_tick  (w_tick)
  );

  // Next-state logic: phase counter advances on ticks, each state leaves on
  // its last tick; blink count drops leaving ON, repeat count leaving GAP.
  always_comb begin
    w_nextState = r_state;
    w_nextPhase = r_phase;
    w_nextBlink = r_blinkCnt;
    w_nextRep   = r_repCnt;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_nextState = ST_ON;
          w_nextPhase = '0;
          w_nextBlink = i_code;
          w_nextRep   = REP_INIT;
        end
      end
      ST_ON: begin
        if (w_tick) begin
          if (r_phase == ON_LAST) begin
            w_nextState = ST_OFF;
            w_nextPhase = '0;
            w_nextBlink = r_blinkCnt - 1'b1;
          end else begin
            w_nextPhase = r_phase + 1'b1;
          end
        end
      end
      ST_OFF: begin
        if (w_tick) begin
          if (r_phase == OFF_LAST) begin
            w_nextPhase = '0;
            w_nextState = (r_blinkCnt != '0) ? ST_ON : ST_GAP;
          end else begin
            w_nextPhase = r_phase + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (w_tick) begin
          if (r_phase == GAP_LAST) begin
            w_nextPhase = '0;
            w_nextRep   = r_repCnt - 1'b1;
            if (r_repCnt == REP_W'(1)) begin
              w_nextState = ST_IDLE;
            end else begin
              w_nextState = ST_ON;
              w_nextBlink = r_code;
            end
          end else begin
            w_nextPhase = r_phase + 1'b1;
          end
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so led/busy change on the same
  // edge as the state itself (accept in cycle k -> lit in cycle k+1)
  always_comb begin
    w_nextLed  = (w_nextState == ST_ON) ||
                 ((w_nextState == ST_IDLE) && i_fade_in);
    w_nextBusy = (w_nextState != ST_IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_phase    <= '0;
      r_blinkCnt <= '0;
      r_code     <= '0;
      r_repCnt   <= '0;
      r_led      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_phase    <= w_nextPhase;
      r_blinkCnt <= w_nextBlink;
      r_repCnt   <= w_nextRep;
      r_led      <= w_nextLed;
      r_busy     <= w_nextBusy;
      if (w_start) begin
        r_code <= i_code;
      end
    end
  end

  assign o_led  = r_led;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_led_blink_code.sv
// ---------------------------------------------------------------------------
// tb_led_blink_code
// Scoreboard bench for led_blink_code with MXTICKCNT=2 (1 tick = 4 clocks).
// The stimulus process drives inputs shortly after each falling edge and
// pushes the outputs expected after the following rising edge; the monitor
// pops one entry per rising edge and compares led/busy/code_ready.
// ---------------------------------------------------------------------------
module tb_led_blink_code;

  localparam int ON_CLKS  = 2 * 4;
  localparam int OFF_CLKS = 3 * 4;
  localparam int GAP_CLKS = 10 * 4;
  localparam int REPEATS  = 3;

  typedef struct packed {
    logic led;
    logic busy;
    logic ready;
  } expT;

  logic       clock = 1'b0;
  logic       reset;
  logic       fadeIn;
  logic [3:0] code;
  logic       codeValid;
  logic       codeReady;
  logic       led;
  logic       busy;

  expT expQ[$];
  bit  patternQ[$];
  int  compared   = 0;
  int  mismatched = 0;

  always #5 clock = ~clock;

  led_blink_code #(
    .MXTICKCNT  (2),
    .MXCODEBITS (4)
  ) dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_fade_in    (fadeIn),
    .i_code       (code),
    .i_code_valid (codeValid),
    .o_code_ready (codeReady),
    .o_led        (led),
    .o_busy       (busy)
  );

  // Drive one cycle of inputs and record what must appear after the next edge
  task automatic applyStimulus(input logic rst, input logic fade, input logic valid,
                               input logic [3:0] cd, input logic eLed,
                               input logic eBusy, input logic eReady);
    expT e;
    @(negedge clock);
    #1;
    reset     = rst;
    fadeIn    = fade;
    codeValid = valid;
    code      = cd;
    e.led     = eLed;
    e.busy    = eBusy;
    e.ready   = eReady;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expT e);
    compared++;
    if ({led, busy, codeReady} !== e) begin
      mismatched++;
      $display("[TB] FAIL outputs t=%0t: led/busy/ready got %b%b%b, expected %b%b%b",
               $time, led, busy, codeReady, e.led, e.busy, e.ready);
    end
  endtask

  // Idle cycles: LED must follow fade_in one clock later
  task automatic idleSteps(input int n);
    logic f;
    for (int i = 0; i < n; i++) begin
      f = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, f, 1'b0, 4'd0, f, 1'b0, 1'b1);
    end
  endtask

  // Hand-derived LED waveform for code n, one entry per busy clock
  task automatic buildPattern(input int n);
    patternQ.delete();
    for (int r = 0; r < REPEATS; r++) begin
      for (int b = 0; b < n; b++) begin
        for (int i = 0; i < ON_CLKS; i++)  patternQ.push_back(1'b1);
        for (int i = 0; i < OFF_CLKS; i++) patternQ.push_back(1'b0);
      end
      for (int i = 0; i < GAP_CLKS; i++) patternQ.push_back(1'b0);
    end
  endtask

  // Full sequence; optionally offer code 5 early on, which must be ignored
  task automatic runCode(input logic [3:0] n, input bit intrude);
    logic v;
    buildPattern(int'(n));
    applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, n, patternQ[0], 1'b1, 1'b0);
    for (int i = 1; i < patternQ.size(); i++) begin
      v = intrude && (i < 50);
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), v, v ? 4'd5 : 4'd0,
                    patternQ[i], 1'b1, 1'b0);
    end
  endtask

  // Monitor: one scoreboard entry per rising edge, sampled 2 ns later
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (expQ.size() > 0) begin
        checkOutput(expQ.pop_front());
      end
    end
  end

  initial begin
    logic f;
    reset     = 1'b1;
    fadeIn    = 1'b0;
    codeValid = 1'b0;
    code      = 4'd0;

    // Held in reset with fade_in high: LED stays dark, ready high
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    $display("[TB] idle pass-through");
    idleSteps(20);

    $display("[TB] code 3");
    runCode(4'd3, 1'b0);
    idleSteps(10);

    $display("[TB] code 0 discarded");
    for (int i = 0; i < 2; i++) begin
      f = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, f, 1'b1, 4'd0, f, 1'b0, 1'b1);
    end
    idleSteps(5);

    $display("[TB] code 3 with code 5 offered while busy");
    runCode(4'd3, 1'b1);
    idleSteps(10);

    $display("[TB] reset in the middle of ON");
    buildPattern(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd2, patternQ[0], 1'b1, 1'b0);
    for (int i = 1; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, patternQ[i], 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    #1;
    compared++;
    if (led !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL asyncReset: led/busy got %b%b, expected 00", led, busy);
    end
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idleSteps(5);
    runCode(4'd2, 1'b0);
    idleSteps(10);

    $display("[TB] code 15");
    runCode(4'd15, 1'b0);
    idleSteps(10);

    @(posedge clock);
    #4;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
